// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit value, and a validity test.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter. The digit stays in 0-9, and step_out ripples the step to the next decade.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t digit,
    output logic       step_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (step_in) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // The ripple is combinational, so every decade settles within the same cycle.
    assign step_out = step_in & (up ? (digit_q == BCD_MAX) : (digit_q == 4'd0));
    assign digit    = digit_q;

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade BCD up/down counter with a validated synchronous load.
// It raises a carry pulse when it wraps and a load_err pulse when it rejects a load.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_val,
    output logic [BCD_W*NUM_DIGITS-1:0]   bcd,
    output logic                          carry,
    output logic                          load_err
);

    logic [NUM_DIGITS:0]   step_w;
    logic [NUM_DIGITS-1:0] valid_w;
    logic                  load_ok;
    logic                  load_accept;
    logic                  carry_q;
    logic                  carry_d;
    logic                  load_err_q;
    logic                  load_err_d;

    // A load cycle swallows the count step, whether the load is accepted or rejected.
    assign step_w[0]   = en & ~load;
    assign load_ok     = &valid_w;
    assign load_accept = load & load_ok;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign valid_w[gi] = bcd_valid(load_val[BCD_W*gi +: BCD_W]);

            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .step_in    (step_w[gi]),
                .up         (up),
                .load       (load_accept),
                .load_digit (load_val[BCD_W*gi +: BCD_W]),
                .digit      (bcd[BCD_W*gi +: BCD_W]),
                .step_out   (step_w[gi+1])
            );
        end
    endgenerate

    assign carry_d    = step_w[NUM_DIGITS];
    assign load_err_d = load & ~load_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (NUM_DIGITS=2). It combines directed scenarios with
// randomized traffic checked against an integer-valued reference model.
module tb_bcd_counter;

    localparam int N    = 2;
    localparam int W    = 4 * N;
    localparam int MODN = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd;
    logic         carry;
    logic         load_err;

    int errors = 0;
    int checks = 0;

    int unsigned model_val;
    logic        exp_carry;
    logic        exp_err;

    bcd_counter #(.NUM_DIGITS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .carry    (carry),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit lv_valid(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int unsigned from_bcd(input logic [W-1:0] v);
        int unsigned r;
        int unsigned scale;
        r = 0;
        scale = 1;
        for (int i = 0; i < N; i++) begin
            r = r + int'(v[4*i +: 4]) * scale;
            scale = scale * 10;
        end
        return r;
    endfunction

    // Drive one cycle, advance the reference model, then sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic ld, input logic [W-1:0] lv,
                         input logic e, input logic u);
        rst = r; load = ld; load_val = lv; en = e; up = u;
        @(posedge clk);
        #1;
        exp_carry = 1'b0;
        exp_err   = 1'b0;
        if (r) begin
            model_val = 0;
        end else if (ld) begin
            if (lv_valid(lv)) model_val = from_bcd(lv);
            else              exp_err = 1'b1;
        end else if (e) begin
            if (u) begin
                exp_carry = (model_val == MODN - 1);
                model_val = (model_val + 1) % MODN;
            end else begin
                exp_carry = (model_val == 0);
                model_val = (model_val + MODN - 1) % MODN;
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
        checks++;
        if (bcd !== 8'h00 || carry !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: bcd=%h carry=%b load_err=%b required 00/0/0", bcd, carry, load_err);
        end
        $display("reset: bcd=%h carry=%b load_err=%b", bcd, carry, load_err);
    endtask

    task automatic test_up_wrap;
        logic [W-1:0] exp_b [3];
        logic         exp_c [3];
        exp_b = '{8'h99, 8'h00, 8'h01};
        exp_c = '{1'b0, 1'b1, 1'b0};
        cycle(1'b0, 1'b1, 8'h98, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if (bcd !== exp_b[i] || carry !== exp_c[i]) begin
                errors++;
                $display("FAIL up_wrap[%0d]: bcd=%h carry=%b required %h/%b", i, bcd, carry, exp_b[i], exp_c[i]);
            end
            $display("up_wrap[%0d]: bcd=%h carry=%b", i, bcd, carry);
        end
    endtask

    task automatic test_down_wrap;
        logic [W-1:0] exp_b [3];
        logic         exp_c [3];
        exp_b = '{8'h00, 8'h99, 8'h98};
        exp_c = '{1'b0, 1'b1, 1'b0};
        cycle(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bcd !== exp_b[i] || carry !== exp_c[i]) begin
                errors++;
                $display("FAIL down_wrap[%0d]: bcd=%h carry=%b required %h/%b", i, bcd, carry, exp_b[i], exp_c[i]);
            end
            $display("down_wrap[%0d]: bcd=%h carry=%b", i, bcd, carry);
        end
        cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bcd !== 8'h09 || carry !== 1'b0) begin
            errors++;
            $display("FAIL mid_borrow: bcd=%h carry=%b required 09/0", bcd, carry);
        end
        $display("mid_borrow: bcd=%h carry=%b", bcd, carry);
    endtask

    task automatic test_invalid_load;
        cycle(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h3A, 1'b1, 1'b1);
        checks++;
        if (bcd !== 8'h42 || load_err !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL invalid_load: bcd=%h load_err=%b carry=%b required 42/1/0", bcd, load_err, carry);
        end
        $display("invalid_load: bcd=%h load_err=%b", bcd, load_err);
        cycle(1'b0, 1'b1, 8'h37, 1'b0, 1'b0);
        checks++;
        if (bcd !== 8'h37 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL valid_load: bcd=%h load_err=%b required 37/0", bcd, load_err);
        end
        $display("valid_load: bcd=%h load_err=%b", bcd, load_err);
    endtask

    task automatic test_priority;
        cycle(1'b0, 1'b1, 8'h50, 1'b1, 1'b1);
        checks++;
        if (bcd !== 8'h50 || carry !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en: bcd=%h carry=%b required 50/0", bcd, carry);
        end
        $display("load_over_en: bcd=%h carry=%b", bcd, carry);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] want;
        cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, (i % 2 == 0));
            want = (i % 2 == 0) ? 8'h00 : 8'h99;
            checks++;
            if (bcd !== want || carry !== 1'b1) begin
                errors++;
                $display("FAIL alt_wrap[%0d]: bcd=%h carry=%b required %h/1", i, bcd, carry, want);
            end
            $display("alt_wrap[%0d]: bcd=%h carry=%b", i, bcd, carry);
        end
    endtask

    task automatic test_sweep;
        int  carries;
        bit  nib_bad;
        carries = 0;
        nib_bad = 1'b0;
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (carry === 1'b1) carries++;
            for (int d = 0; d < N; d++) begin
                if (!(bcd[4*d +: 4] <= 4'd9)) nib_bad = 1'b1;
            end
            checks++;
            if (bcd !== to_bcd(model_val)) begin
                errors++;
                $display("FAIL sweep[%0d]: bcd=%h required %h", i, bcd, to_bcd(model_val));
            end
        end
        checks++;
        if (bcd !== 8'h00 || carries != 1 || nib_bad) begin
            errors++;
            $display("FAIL sweep_end: bcd=%h carries=%0d bad_nibble=%b required 00/1/0", bcd, carries, nib_bad);
        end
        $display("sweep_end: bcd=%h carries=%0d", bcd, carries);
    endtask

    task automatic test_random;
        logic         r, ld, e, u;
        logic [W-1:0] lv;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) == 1;
            lv = W'($urandom);
            cycle(r, ld, lv, e, u);
            checks++;
            if (bcd !== to_bcd(model_val) || carry !== exp_carry || load_err !== exp_err) begin
                errors++;
                $display("FAIL random[%0d]: bcd=%h carry=%b load_err=%b required %h/%b/%b",
                         i, bcd, carry, load_err, to_bcd(model_val), exp_carry, exp_err);
            end
        end
        $display("random: %0d cycles compared", 400);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        model_val = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_invalid_load;
        test_priority;
        test_back_to_back;
        test_sweep;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
